// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers,
// with space-aware throttling and per-requester routing of wr_ack/overflow.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            err,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow
);

    localparam int              IDW       = $clog2(NUM_REQ);
    localparam logic [IDW:0]    NREQ_W    = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0]  LAST_IDX  = IDW'(NUM_REQ - 1);
    localparam logic [3:0]      BURST_MAX = 4'(BURST_LEN);

    // Handshake: a producer holds req and its wdata slice; the beat is consumed in
    // the cycle gnt[i] is high and the producer may present the next beat after it.
    logic [IDW-1:0]        last_q, last_d;
    logic [3:0]            burst_q, burst_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]        id1_q, id1_d, id2_q, id2_d;
    logic                  id1_vld_q, id1_vld_d, id2_vld_q, id2_vld_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d, err_q, err_d;

    logic                  space_ok;
    logic                  keep;
    logic                  found;
    logic                  grant_vld;
    logic [IDW-1:0]        grant_id;
    logic [IDW-1:0]        pick;
    logic [IDW-1:0]        rr_base;
    logic [IDW:0]          rr_sum;
    logic [FIFO_WIDTH-1:0] wsel;

    always_comb begin
        // The almostfull term accounts for the write already registered this cycle.
        space_ok = !full && !(almostfull && wr_en_q);
        keep     = (burst_q != 4'd0) && req[last_q] && (burst_q < BURST_MAX);
        rr_base  = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

        found  = 1'b0;
        pick   = rr_base;
        rr_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, rr_base} + (IDW+1)'(k);
            if (rr_sum >= NREQ_W) rr_sum = rr_sum - NREQ_W;
            if (!found && req[rr_sum[IDW-1:0]]) begin
                found = 1'b1;
                pick  = rr_sum[IDW-1:0];
            end
        end

        grant_vld = 1'b0;
        grant_id  = last_q;
        if (space_ok) begin
            if (keep) begin
                grant_vld = 1'b1;
                grant_id  = last_q;
            end else if (found) begin
                grant_vld = 1'b1;
                grant_id  = pick;
            end
        end

        wsel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) wsel = wdata[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    always_comb begin
        last_d  = last_q;
        burst_d = burst_q;
        if (grant_vld) begin
            last_d  = grant_id;
            burst_d = keep ? burst_q + 4'd1 : 4'd1;
        end else if (!req[last_q]) begin
            burst_d = 4'd0;
        end

        wr_en_d   = grant_vld;
        data_d    = grant_vld ? wsel : data_q;
        id1_vld_d = grant_vld;
        id1_d     = grant_vld ? grant_id : id1_q;
        id2_vld_d = id1_vld_q;
        id2_d     = id1_q;

        // Overflow wins over wr_ack; responses with no tracked ID are dropped.
        ack_d = '0;
        err_d = '0;
        if (id2_vld_q) begin
            if (overflow)    err_d = NUM_REQ'(1) << id2_q;
            else if (wr_ack) ack_d = NUM_REQ'(1) << id2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= LAST_IDX;
            burst_q   <= 4'd0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            id1_q     <= '0;
            id1_vld_q <= 1'b0;
            id2_q     <= '0;
            id2_vld_q <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            last_q    <= last_d;
            burst_q   <= burst_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            id1_q     <= id1_d;
            id1_vld_q <= id1_vld_d;
            id2_q     <= id2_d;
            id2_vld_q <= id2_vld_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign gnt     = (grant_vld && rst_n) ? (NUM_REQ'(1) << grant_id) : '0;
    assign ack     = ack_q;
    assign err     = err_q;
    assign wr_en   = wr_en_q;
    assign data_in = data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural depth-8 FIFO on the write side.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   breq = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt, ack, err;
  logic           wr_en;
  logic [W-1:0]   data_in;
  logic           full, almostfull;
  logic           wr_ack = 1'b0;
  logic           overflow = 1'b0;
  logic [N-1:0]   bgnt, back, berr;
  logic           bwr_en;
  logic [W-1:0]   bdata_in;

  logic           fifo_clr = 1'b1;
  logic           rd_en = 1'b0;
  logic           spur_ack = 1'b0;
  int             inj_mode = 0;
  int             fifo_cnt = 0;

  int             errors = 0;
  int             checks = 0;
  logic [W-1:0]   exp_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack), .err(err),
    .wr_en(wr_en), .data_in(data_in), .full(full), .almostfull(almostfull),
    .wr_ack(wr_ack), .overflow(overflow)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(3)) u_burst (
    .clk(clk), .rst_n(rst_n), .req(breq), .wdata(wdata), .gnt(bgnt), .ack(back), .err(berr),
    .wr_en(bwr_en), .data_in(bdata_in), .full(1'b0), .almostfull(1'b0),
    .wr_ack(1'b0), .overflow(1'b0)
  );

  // FIFO model: flags come from the registered count; inj_mode 1 = overflow only,
  // 2 = wr_ack and overflow together; spur_ack raises wr_ack with no write.
  assign full       = (fifo_cnt == DEPTH);
  assign almostfull = (fifo_cnt == DEPTH - 1);

  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_cnt <= 0;
      wr_ack   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ack   <= (wr_en && !full && inj_mode != 1) || spur_ack;
      overflow <= wr_en && (full || inj_mode != 0);
      fifo_cnt <= fifo_cnt + ((wr_en && !full && inj_mode == 0) ? 1 : 0)
                           - ((rd_en && fifo_cnt != 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wdata(input int c);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = W'((i << 12) + c);
      wdata[i*W +: W] = v;
    end
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    fifo_clr = 1'b1;
    req      = '0;
    breq     = '0;
    rd_en    = 1'b0;
    inj_mode = 0;
    spur_ack = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    fifo_clr = 1'b1;
    req      = '1;
    set_wdata(5);
    #3;
    checks++; if (gnt !== '0)     $display("FAIL reset_gnt got=%b exp=0", gnt);
    if (gnt !== '0) errors++;
    checks++; if (ack !== '0)     begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (err !== '0)     begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (data_in !== '0) begin errors++; $display("FAIL reset_data_in got=%h exp=0", data_in); end
    tick();
    tick();
    req      = '0;
    rst_n    = 1'b1;
    fifo_clr = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [N-1:0] exp_gnt, exp_ack;
    logic         exp_wr;
    logic [W-1:0] exp_d;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      req = (c < 5) ? 4'b0100 : 4'b0000;
      set_wdata(c);
      @(negedge clk);
      exp_gnt = (c < 5) ? 4'b0100 : 4'b0000;
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      if (exp_gnt[2]) exp_q.push_back(W'(16'h2000 + c));
      exp_wr = (c >= 1 && c <= 5);
      checks++; if (wr_en !== exp_wr) begin errors++; $display("FAIL single_wr_en c=%0d got=%b exp=%b", c, wr_en, exp_wr); end
      if (exp_wr) begin
        exp_d = exp_q.pop_front();
        checks++; if (data_in !== exp_d) begin errors++; $display("FAIL single_data c=%0d got=%h exp=%h", c, data_in, exp_d); end
      end
      exp_ack = (c >= 3 && c <= 7) ? 4'b0100 : 4'b0000;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL single_ack c=%0d got=%b exp=%b", c, ack, exp_ack); end
      checks++; if (err !== '0) begin errors++; $display("FAIL single_err c=%0d got=%b exp=0", c, err); end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_gnt, exp_ack;
    reset_dut();
    rd_en = 1'b1;
    req   = '1;
    for (int c = 0; c < 12; c++) begin
      set_wdata(c);
      @(negedge clk);
      exp_gnt = N'(1) << (c % 4);
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      exp_ack = (c >= 3) ? N'(1) << ((c - 3) % 4) : '0;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL fair_ack c=%0d got=%b exp=%b", c, ack, exp_ack); end
      tick();
    end
    req = '0;
    for (int c = 0; c < 4; c++) tick();
    rd_en = 1'b0;
  endtask

  task automatic test_burst();
    logic [N-1:0] seq_a [0:6];
    logic [N-1:0] req_b [0:4];
    logic [N-1:0] seq_b [0:4];
    seq_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    req_b = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011};
    seq_b = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    reset_dut();
    breq = 4'b0011;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++; if (bgnt !== seq_a[c]) begin errors++; $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, bgnt, seq_a[c]); end
      tick();
    end
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      breq = req_b[c];
      @(negedge clk);
      checks++; if (bgnt !== seq_b[c]) begin errors++; $display("FAIL burst_drop_gnt c=%0d got=%b exp=%b", c, bgnt, seq_b[c]); end
      tick();
    end
    breq = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_gnt;
    int           gcount;
    int           ovf_hits;
    gcount   = 0;
    ovf_hits = 0;
    reset_dut();
    req = '1;
    for (int c = 0; c < 17; c++) begin
      rd_en = (c == 12);
      set_wdata(c);
      @(negedge clk);
      if (c < 8)        exp_gnt = N'(1) << (c % 4);
      else if (c == 13) exp_gnt = 4'b0001;
      else              exp_gnt = '0;
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL bp_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      if (|gnt) gcount++;
      if (overflow) ovf_hits++;
      tick();
    end
    rd_en = 1'b0;
    req   = '0;
    checks++; if (gcount !== 9) begin errors++; $display("FAIL bp_grant_count got=%0d exp=9", gcount); end
    checks++; if (ovf_hits !== 0) begin errors++; $display("FAIL bp_overflow_seen got=%0d exp=0", ovf_hits); end
  endtask

  task automatic test_err_routing();
    logic [N-1:0] exp_err;
    reset_dut();
    rd_en    = 1'b1;
    inj_mode = 1;
    for (int c = 0; c < 6; c++) begin
      req = (c == 0) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      exp_err = (c == 3) ? 4'b1000 : 4'b0000;
      checks++; if (err !== exp_err) begin errors++; $display("FAIL ovf_err c=%0d got=%b exp=%b", c, err, exp_err); end
      checks++; if (ack !== '0) begin errors++; $display("FAIL ovf_ack c=%0d got=%b exp=0", c, ack); end
      tick();
    end
    inj_mode = 2;
    for (int c = 0; c < 6; c++) begin
      req = (c == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      exp_err = (c == 3) ? 4'b0010 : 4'b0000;
      checks++; if (err !== exp_err) begin errors++; $display("FAIL both_err c=%0d got=%b exp=%b", c, err, exp_err); end
      checks++; if (ack !== '0) begin errors++; $display("FAIL both_ack c=%0d got=%b exp=0", c, ack); end
      tick();
    end
    inj_mode = 0;
    for (int c = 0; c < 6; c++) begin
      spur_ack = (c < 3);
      @(negedge clk);
      checks++; if (ack !== '0) begin errors++; $display("FAIL spur_ack c=%0d got=%b exp=0", c, ack); end
      tick();
    end
    spur_ack = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] seq [0:3];
    logic [N-1:0] exp_gnt, exp_ack;
    seq = '{4'b0100, 4'b1000, 4'b0100, 4'b1000};
    reset_dut();
    rd_en = 1'b1;
    req   = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      set_wdata(c + 1);
      @(negedge clk);
      checks++; if (gnt !== seq[c]) begin errors++; $display("FAIL mid_gnt c=%0d got=%b exp=%b", c, gnt, seq[c]); end
      if (c < 3) tick();
    end
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL mid_ack_pre got=%b exp=0100", ack); end
    #1;
    rst_n = 1'b0;
    req   = '0;
    #1;
    checks++; if (gnt !== '0)     begin errors++; $display("FAIL mid_rst_gnt got=%b exp=0", gnt); end
    checks++; if (ack !== '0)     begin errors++; $display("FAIL mid_rst_ack got=%b exp=0", ack); end
    checks++; if (err !== '0)     begin errors++; $display("FAIL mid_rst_err got=%b exp=0", err); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en got=%b exp=0", wr_en); end
    checks++; if (data_in !== '0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", data_in); end
    #1;
    rst_n = 1'b1;
    tick();
    for (int c = 4; c < 8; c++) begin
      req = (c == 4) ? 4'b1100 : 4'b0000;
      @(negedge clk);
      exp_gnt = (c == 4) ? 4'b0100 : 4'b0000;
      exp_ack = (c == 7) ? 4'b0100 : 4'b0000;
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL mid_post_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL mid_post_ack c=%0d got=%b exp=%b", c, ack, exp_ack); end
      tick();
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_backpressure();
    test_err_routing();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
